// File: rtl/stream_demux_collector_pkg.sv
// Shared fixed-point constants and the collector state encoding.
package stream_demux_collector_pkg;

    localparam int INT_LENGTH  = 5;
    localparam int FRAC_LENGTH = 12;
    localparam int NUM_OUT     = 4;

    function automatic int fx_width(input int int_len, input int frac_len);
        return int_len + frac_len;
    endfunction

    localparam int W = fx_width(INT_LENGTH, FRAC_LENGTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/stream_demux_collector_if.sv
// Result stream in, parallel frame out, for the demux collector.
interface stream_demux_collector_if
    import stream_demux_collector_pkg::*;
#(
    parameter int WIDTH = W,
    parameter int SLOTS = NUM_OUT,
    parameter int CW    = $clog2(SLOTS)
);
    logic                   start;
    logic                   abort;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic [CW-1:0]          sel_idx;
    logic [SLOTS*WIDTH-1:0] out_data;
    logic                   out_valid;
    logic                   out_ack;
    logic                   busy;
    logic                   err;

    modport master (
        output start, abort, in_valid, in_data, out_ack,
        input  in_ready, sel_idx, out_data, out_valid, busy, err
    );

    modport slave (
        input  start, abort, in_valid, in_data, out_ack,
        output in_ready, sel_idx, out_data, out_valid, busy, err
    );
endinterface

// File: rtl/stream_demux_collector_slot_bank.sv
// NUM_OUT x W result register bank with indexed write, flattened read-out.
module demux_slot_bank
    import stream_demux_collector_pkg::*;
#(
    parameter int WIDTH = W,
    parameter int SLOTS = NUM_OUT,
    parameter int CW    = $clog2(SLOTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [CW-1:0]          wr_idx,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [SLOTS*WIDTH-1:0] out_data
);
    logic [WIDTH-1:0] slots [SLOTS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SLOTS; k++) slots[k] <= '0;
        end else if (wr_en) begin
            slots[wr_idx] <= wr_data;
        end
    end

    for (genvar k = 0; k < SLOTS; k++) begin : g_flat
        assign out_data[k*WIDTH +: WIDTH] = slots[k];
    end
endmodule

// File: rtl/stream_demux_collector.sv
// Steers serial datapath results into a slot bank and hands out whole frames.
// Optional overrun flag: define DEMUX_OVERRUN_ERR_EN.
module stream_demux_collector
    import stream_demux_collector_pkg::*;
#(
    parameter int INT_LEN  = INT_LENGTH,
    parameter int FRAC_LEN = FRAC_LENGTH,
    parameter int SLOTS    = NUM_OUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    stream_demux_collector_if.slave   bus
);
    localparam int WIDTH = fx_width(INT_LEN, FRAC_LEN);
    localparam int CW    = $clog2(SLOTS);
    localparam logic [CW-1:0] LAST = CW'(SLOTS - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          wr_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = COLLECT;
                    cnt_nx   = '0;
                end
            end
            COLLECT: begin
                // abort outranks a coincident transfer
                if (bus.abort) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (bus.in_valid) begin
                    wr_en = 1'b1;
                    if (cnt == LAST) begin
                        state_nx = HOLD;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (bus.out_ack) begin
                    state_nx = bus.start ? COLLECT : IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign bus.in_ready  = (state == COLLECT);
    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state != IDLE);
    assign bus.sel_idx   = cnt;

`ifdef DEMUX_OVERRUN_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (bus.in_valid && state != COLLECT) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    demux_slot_bank #(
        .WIDTH(WIDTH),
        .SLOTS(SLOTS),
        .CW   (CW)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (cnt),
        .wr_data (bus.in_data),
        .out_data(bus.out_data)
    );
endmodule

// File: tb/tb_stream_demux_collector.sv
// Randomised self-checking bench for stream_demux_collector.
module tb_stream_demux_collector;
    import stream_demux_collector_pkg::*;

    localparam int N  = NUM_OUT;
    localparam int CW = $clog2(N);
    localparam int OW = 4 + CW + N*W;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stream_demux_collector_if #(.WIDTH(W), .SLOTS(N)) sif();

    stream_demux_collector dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sif.slave)
    );

    // Reference: frame phase 0 = idle, 1 = filling, 2 = frame ready.
    int           m_phase;
    int           m_fill;
    logic [W-1:0] m_slot [N];
    logic         m_err;

`ifdef DEMUX_OVERRUN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic model_edge();
        if (!rst_n) begin
            m_phase = 0;
            m_fill  = 0;
            m_err   = 1'b0;
            for (int k = 0; k < N; k++) m_slot[k] = '0;
            return;
        end
        if (ERR_EN && sif.in_valid && m_phase != 1) m_err = 1'b1;
        if (m_phase == 0) begin
            if (sif.start) begin
                m_phase = 1;
                m_fill  = 0;
            end
        end else if (sif.abort) begin
            m_phase = 0;
            m_fill  = 0;
        end else if (m_phase == 1) begin
            if (sif.in_valid) begin
                m_slot[m_fill] = sif.in_data;
                m_fill++;
                if (m_fill == N) begin
                    m_phase = 2;
                    m_fill  = 0;
                end
            end
        end else if (sif.out_ack) begin
            m_phase = sif.start ? 1 : 0;
            m_fill  = 0;
        end
    endtask

    function automatic logic [OW-1:0] expect_vec();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = m_slot[k];
        return {m_phase == 1, m_phase == 2, m_phase != 0,
                m_err, CW'(m_fill), d};
    endfunction

    function automatic logic [OW-1:0] obs_vec();
        return {sif.in_ready, sif.out_valid, sif.busy,
                sif.err, sif.sel_idx, sif.out_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sif.start    = 1'b0;
        sif.abort    = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        sif.out_ack  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset outputs got %h want 0", obs_vec());
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        logic [W-1:0]   d [4];
        logic [N*W-1:0] want;
        d[0] = 17'h00001; d[1] = 17'h00002;
        d[2] = 17'h1FFFF; d[3] = 17'h10000;
        want = {17'h10000, 17'h1FFFF, 17'h00002, 17'h00001};
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sif.in_ready !== 1'b1 || sif.sel_idx !== CW'(i)) begin
                errors++;
                $display("FAIL frame ready/sel got %b/%0d want 1/%0d",
                         sif.in_ready, sif.sel_idx, i);
            end
            sif.in_valid = 1'b1;
            sif.in_data  = d[i];
            tick();
        end
        sif.in_valid = 1'b0;
        checks++;
        if (sif.out_valid !== 1'b1 || sif.out_data !== want) begin
            errors++;
            $display("FAIL frame out got %b %h want 1 %h",
                     sif.out_valid, sif.out_data, want);
        end
        sif.out_ack = 1'b1;
        tick();
        sif.out_ack = 1'b0;
        checks++;
        if (obs_vec() !== expect_vec() || sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL frame ack got %h want %h", obs_vec(), expect_vec());
        end
    endtask

    task automatic test_gaps();
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            sif.in_valid = (c == 1 || c == 3 || c == 4 || c == 7);
            sif.in_data  = W'($urandom);
            tick();
            checks++;
            if (obs_vec() !== expect_vec()) begin
                errors++;
                $display("FAIL gaps cycle %0d got %h want %h",
                         c, obs_vec(), expect_vec());
            end
        end
        sif.in_valid = 1'b0;
        checks++;
        if (sif.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL gaps complete got %b want 1", sif.out_valid);
        end
        sif.out_ack = 1'b1;
        tick();
        sif.out_ack = 1'b0;
    endtask

    task automatic test_hold_ack_delay();
        logic [N*W-1:0] held;
        logic [W-1:0]   nd;
        sif.start = 1'b1;
        tick();
        sif.start    = 1'b0;
        sif.in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            sif.in_data = W'($urandom);
            tick();
        end
        held = sif.out_data;
        for (int c = 0; c < 5; c++) begin
            sif.in_data = W'($urandom);
            tick();
            checks++;
            if (sif.in_ready !== 1'b0 || sif.out_data !== held
                || obs_vec() !== expect_vec()) begin
                errors++;
                $display("FAIL hold cycle %0d got %h want %h",
                         c, obs_vec(), expect_vec());
            end
        end
        sif.in_valid = 1'b0;
        sif.out_ack  = 1'b1;
        sif.start    = 1'b1;
        tick();
        sif.out_ack = 1'b0;
        sif.start   = 1'b0;
        checks++;
        if (sif.in_ready !== 1'b1 || sif.sel_idx !== '0) begin
            errors++;
            $display("FAIL b2b ready/sel got %b/%0d want 1/0",
                     sif.in_ready, sif.sel_idx);
        end
        nd = W'($urandom);
        sif.in_valid = 1'b1;
        sif.in_data  = nd;
        tick();
        sif.in_valid = 1'b0;
        checks++;
        if (sif.out_data[W-1:0] !== nd || obs_vec() !== expect_vec()) begin
            errors++;
            $display("FAIL b2b slot0 got %h want %h", sif.out_data[W-1:0], nd);
        end
        sif.abort = 1'b1;
        tick();
        sif.abort = 1'b0;
    endtask

    task automatic test_abort();
        logic [W-1:0] aa;
        sif.start = 1'b1;
        tick();
        sif.start    = 1'b0;
        sif.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sif.in_data = W'($urandom);
            tick();
        end
        sif.abort   = 1'b1;
        sif.in_data = W'($urandom);
        tick();
        sif.abort    = 1'b0;
        sif.in_valid = 1'b0;
        checks++;
        if (sif.busy !== 1'b0 || obs_vec() !== expect_vec()) begin
            errors++;
            $display("FAIL abort got %h want %h", obs_vec(), expect_vec());
        end
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        aa = 17'h0AAAA;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (sif.out_valid !== 1'b0 || sif.sel_idx !== CW'(i)) begin
                errors++;
                $display("FAIL abort refill valid/sel got %b/%0d want 0/%0d",
                         sif.out_valid, sif.sel_idx, i);
            end
            sif.in_valid = 1'b1;
            sif.in_data  = aa + W'(i);
            tick();
        end
        sif.in_valid = 1'b0;
        checks++;
        if (sif.out_valid !== 1'b1 || sif.out_data[W-1:0] !== aa
            || obs_vec() !== expect_vec()) begin
            errors++;
            $display("FAIL abort refill got %h want %h", obs_vec(), expect_vec());
        end
        sif.out_ack = 1'b1;
        tick();
        sif.out_ack = 1'b0;
    endtask

    task automatic test_reset_midframe();
        sif.start = 1'b1;
        tick();
        sif.start    = 1'b0;
        sif.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sif.in_data = W'($urandom) | W'(1);
            tick();
        end
        sif.in_valid = 1'b0;
        checks++;
        if (sif.sel_idx !== CW'(3)) begin
            errors++;
            $display("FAIL midreset pre sel got %0d want 3", sif.sel_idx);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL midreset outputs got %h want 0", obs_vec());
        end
    endtask

    task automatic test_err();
        sif.in_valid = 1'b1;
        sif.in_data  = W'($urandom);
        tick();
        sif.in_valid = 1'b0;
        checks++;
        if (sif.err !== ERR_EN) begin
            errors++;
            $display("FAIL err idle got %b want %b", sif.err, ERR_EN);
        end
        sif.start = 1'b1;
        tick();
        sif.start    = 1'b0;
        sif.in_valid = 1'b1;
        for (int i = 0; i < N; i++) tick();
        sif.in_valid = 1'b0;
        sif.out_ack  = 1'b1;
        tick();
        sif.out_ack = 1'b0;
        checks++;
        if (sif.err !== ERR_EN || obs_vec() !== expect_vec()) begin
            errors++;
            $display("FAIL err sticky got %b want %b", sif.err, ERR_EN);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (sif.err !== 1'b0) begin
            errors++;
            $display("FAIL err clear got %b want 0", sif.err);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            sif.start    = ($urandom_range(0, 3) == 0);
            sif.abort    = ($urandom_range(0, 19) == 0);
            sif.in_valid = ($urandom_range(0, 2) != 0);
            sif.in_data  = W'($urandom);
            sif.out_ack  = ($urandom_range(0, 2) == 0);
            rst_n        = ($urandom_range(0, 99) != 0);
            tick();
            checks++;
            if (obs_vec() !== expect_vec()) begin
                errors++;
                $display("FAIL random cycle %0d got %h want %h",
                         c, obs_vec(), expect_vec());
            end
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        m_phase = 0;
        m_fill  = 0;
        m_err   = 1'b0;
        for (int k = 0; k < N; k++) m_slot[k] = '0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_gaps();
        test_hold_ack_delay();
        test_abort();
        test_reset_midframe();
        test_err();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
